// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if : handshake/bus bundle between the E-stage control and the
//          multiply/divide scheduler.
//
//   Start     E-stage instruction is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//   MDOp      operation select sampled with Start (0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
//   A, B      rs / rt operands
//   MTHI/MTLO write A into HI / LO
//   D_MDType  D-stage instruction is any MD-type instruction (incl. MFHI/MFLO)
//   Busy      operation in progress
//   Stall     stall request to the hazard unit
//   HI, LO    architectural HI/LO registers
//
// master: the pipeline side that drives requests.
// slave : the scheduler itself.
// ---------------------------------------------------------------------------
interface mdu_if;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MTHI;
    logic        MTLO;
    logic        D_MDType;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDOp, A, B, MTHI, MTLO, D_MDType,
        input  Busy, Stall, HI, LO
    );

    modport slave (
        input  Start, MDOp, A, B, MTHI, MTLO, D_MDType,
        output Busy, Stall, HI, LO
    );
endinterface

// File: rtl/mdu_scheduler.sv
// ---------------------------------------------------------------------------
// mdu_scheduler : multi-cycle multiply/divide unit sitting in the E stage.
//
// The full result is computed in the Start cycle and parked in pending
// registers; a countdown then models the unit latency, and HI/LO are only
// updated on the final busy edge, so intermediate values are never visible.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    mdu_if.slave (Start, MDOp, A, B, MTHI, MTLO, D_MDType in;
//                        Busy, Stall, HI, LO out)
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (>= 1)
// ---------------------------------------------------------------------------
module mdu_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic               pwr_q, pwr_d;

    logic               busy_s;
    logic               start_s;
    logic               commit_s;
    logic               mt_en_s;

    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic [31:0]        a_mag_s, b_mag_s, sdiv_s, udiv_s;
    logic [31:0]        sq_s, sr_s, uq_s, ur_s;
    logic [31:0]        res_hi_s, res_lo_s;
    logic               res_wr_s;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Full result of the requested operation, evaluated from the current operands.
    // Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        smul_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        umul_s   = {32'h0, bus.A} * {32'h0, bus.B};
        a_mag_s  = bus.A[31] ? neg32(bus.A) : bus.A;
        b_mag_s  = bus.B[31] ? neg32(bus.B) : bus.B;
        // A zero divisor is replaced by 1 only to keep the dividers defined;
        // the result is never written back in that case.
        sdiv_s   = (b_mag_s == 32'h0) ? 32'd1 : b_mag_s;
        udiv_s   = (bus.B == 32'h0) ? 32'd1 : bus.B;
        sq_s     = a_mag_s / sdiv_s;
        sr_s     = a_mag_s % sdiv_s;
        uq_s     = bus.A / udiv_s;
        ur_s     = bus.A % udiv_s;
        res_hi_s = 32'h0;
        res_lo_s = 32'h0;
        res_wr_s = 1'b0;
        case (bus.MDOp)
            2'd0: begin
                {res_hi_s, res_lo_s} = smul_s;
                res_wr_s             = 1'b1;
            end
            2'd1: begin
                {res_hi_s, res_lo_s} = umul_s;
                res_wr_s             = 1'b1;
            end
            2'd2: begin
                res_lo_s = (bus.A[31] ^ bus.B[31]) ? neg32(sq_s) : sq_s;
                res_hi_s = bus.A[31] ? neg32(sr_s) : sr_s;
                res_wr_s = (bus.B != 32'h0);
            end
            2'd3: begin
                res_lo_s = uq_s;
                res_hi_s = ur_s;
                res_wr_s = (bus.B != 32'h0);
            end
            default: begin
                res_hi_s = 32'h0;
                res_lo_s = 32'h0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // FSM state and countdown register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: load the latency on Start, count down while running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    cnt_d   = bus.MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: busy flag and the datapath enables derived from the state.
    always_comb begin
        busy_s   = 1'b0;
        start_s  = 1'b0;
        commit_s = 1'b0;
        mt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_s = bus.Start;
                // Start wins over a same-cycle MTHI/MTLO.
                mt_en_s = ~bus.Start;
            end
            ST_RUN: begin
                busy_s   = 1'b1;
                commit_s = (cnt_q == CNT_W'(1));
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // HI/LO and pending-result next values.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        pwr_d = pwr_q;
        if (commit_s && pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
        end else if (mt_en_s) begin
            if (bus.MTHI) begin
                hi_d = bus.A;
            end else begin
                hi_d = hi_q;
            end
            if (bus.MTLO) begin
                lo_d = bus.A;
            end else begin
                lo_d = lo_q;
            end
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
        if (start_s) begin
            phi_d = res_hi_s;
            plo_d = res_lo_s;
            pwr_d = res_wr_s;
        end else begin
            phi_d = phi_q;
            plo_d = plo_q;
            pwr_d = pwr_q;
        end
    end

    // HI/LO and pending-result registers; reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            phi_q <= 32'h0;
            plo_q <= 32'h0;
            pwr_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            pwr_q <= pwr_d;
        end
    end

    assign bus.Busy  = busy_s;
    // Stall is combinational so a D-stage MD instruction is held in the Start cycle too.
    assign bus.Stall = bus.D_MDType & (bus.Start | busy_s);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mdu_scheduler : directed bench for mdu_scheduler with a behavioural
// model (remaining-busy-cycle count plus 64-bit integer arithmetic) checked
// every cycle, and hand-computed literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_mdu_scheduler;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mdu_if bus ();

    mdu_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {write, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] model_calc(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                q = sa * sb;
                return {1'b1, q[63:0]};
            end
            2'd1: begin
                p = {32'h0, a} * {32'h0, b};
                return {1'b1, p};
            end
            2'd2: begin
                if (b == 32'h0) return {1'b0, 64'h0};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b0, 64'h0};
                return {1'b1, a % b, a / b};
            end
        endcase
    endfunction

    // Behavioural model: busy cycles left, architectural HI/LO, parked result.
    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_phi  <= 32'h0;
            m_plo  <= 32'h0;
            m_pwr  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_pwr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (bus.Start) begin
            {m_pwr, m_phi, m_plo} <= model_calc(bus.MDOp, bus.A, bus.B);
            m_left <= (bus.MDOp >= 2'd2) ? 10 : 5;
        end else begin
            if (bus.MTHI) m_hi <= bus.A;
            if (bus.MTLO) m_lo <= bus.A;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("model_busy",  {31'h0, bus.Busy},  {31'h0, (m_left > 0)});
            chk("model_stall", {31'h0, bus.Stall}, {31'h0, bus.D_MDType & (bus.Start | (m_left > 0))});
            chk("model_hi", bus.HI, m_hi);
            chk("model_lo", bus.LO, m_lo);
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        cyc();
        bus.Start = 1'b0;
    endtask

    // Start an op, expect n busy cycles, then the given HI/LO with Busy low.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(op, a, b);
        for (int i = 0; i < n; i++) begin
            #1 chk({name, "_busy"}, {31'h0, bus.Busy}, 32'h1);
            cyc();
        end
        #1;
        chk({name, "_done"}, {31'h0, bus.Busy}, 32'h0);
        chk({name, "_hi"}, bus.HI, exp_hi);
        chk({name, "_lo"}, bus.LO, exp_lo);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.Start    = 1'b0;
        bus.MDOp     = 2'd0;
        bus.A        = 32'h0;
        bus.B        = 32'h0;
        bus.MTHI     = 1'b0;
        bus.MTLO     = 1'b0;
        bus.D_MDType = 1'b0;
        #1 reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", {31'h0, bus.Busy}, 32'h0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        reset = 1'b0;
        cyc();

        // MULT -2 * 3: HI/LO stay 0 through five busy cycles.
        bus.Start = 1'b1; bus.MDOp = 2'd0; bus.A = 32'hFFFF_FFFE; bus.B = 32'd3;
        #1 chk("mult_start_busy", {31'h0, bus.Busy}, 32'h0);
        cyc();
        bus.Start = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            #1;
            chk("mult_busy", {31'h0, bus.Busy}, 32'h1);
            chk("mult_hi_hold", bus.HI, 32'h0);
            chk("mult_lo_hold", bus.LO, 32'h0);
            cyc();
        end
        #1;
        chk("mult_done", {31'h0, bus.Busy}, 32'h0);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3.
        run_op("multu", 2'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

        // DIV -7 / 2 with a D-stage MD instruction waiting.
        bus.D_MDType = 1'b1;
        bus.Start = 1'b1; bus.MDOp = 2'd2; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2;
        #1 chk("div_stall_start", {31'h0, bus.Stall}, 32'h1);
        cyc();
        bus.Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("div_stall_busy", {31'h0, bus.Stall}, 32'h1);
            chk("div_busy", {31'h0, bus.Busy}, 32'h1);
            cyc();
        end
        #1;
        chk("div_stall_end", {31'h0, bus.Stall}, 32'h0);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        bus.D_MDType = 1'b0;

        // MTHI then DIVU by zero: HI/LO untouched.
        do_reset();
        bus.MTHI = 1'b1; bus.A = 32'h1234_5678;
        cyc();
        bus.MTHI = 1'b0;
        #1 chk("mthi_hi", bus.HI, 32'h1234_5678);
        run_op("divu0", 2'd3, 32'd5, 32'd0, 10, 32'h1234_5678, 32'h0000_0000);

        // Reset in the third busy cycle of MULT 2 * 3.
        start_op(2'd0, 32'd2, 32'd3);
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, bus.Busy}, 32'h0);
        chk("abort_hi", bus.HI, 32'h0);
        chk("abort_lo", bus.LO, 32'h0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("abort_hi_stay", bus.HI, 32'h0);
            chk("abort_lo_stay", bus.LO, 32'h0);
            chk("abort_busy_stay", {31'h0, bus.Busy}, 32'h0);
            cyc();
        end

        // DIV 100 / 7 with a stray Start(MULT) and MTLO mid-run.
        start_op(2'd2, 32'd100, 32'd7);
        cyc();
        bus.Start = 1'b1; bus.MDOp = 2'd0; bus.MTLO = 1'b1; bus.A = 32'h0000_AAAA; bus.B = 32'd3;
        cyc();
        bus.Start = 1'b0; bus.MTLO = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            #1;
            chk("ign_busy", {31'h0, bus.Busy}, 32'h1);
            chk("ign_lo_hold", bus.LO, 32'h0);
            cyc();
        end
        #1;
        chk("ign_done", {31'h0, bus.Busy}, 32'h0);
        chk("ign_lo", bus.LO, 32'h0000_000E);
        chk("ign_hi", bus.HI, 32'h0000_0002);

        // Start together with MTHI/MTLO: the MT write is dropped.
        bus.MTHI = 1'b1; bus.MTLO = 1'b1;
        start_op(2'd1, 32'd7, 32'd1);
        bus.MTHI = 1'b0; bus.MTLO = 1'b0;
        #1;
        chk("mtdrop_hi", bus.HI, 32'h0000_0002);
        chk("mtdrop_lo", bus.LO, 32'h0000_000E);
        for (int i = 0; i < 5; i++) cyc();
        #1;
        chk("mtdrop_res_hi", bus.HI, 32'h0000_0000);
        chk("mtdrop_res_lo", bus.LO, 32'h0000_0007);

        // MTHI and MTLO together.
        bus.MTHI = 1'b1; bus.MTLO = 1'b1; bus.A = 32'hCAFE_F00D;
        cyc();
        bus.MTHI = 1'b0; bus.MTLO = 1'b0;
        #1;
        chk("mtboth_hi", bus.HI, 32'hCAFE_F00D);
        chk("mtboth_lo", bus.LO, 32'hCAFE_F00D);

        // Signed division corner cases.
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("div_negb", 2'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div0", 2'd2, 32'd9, 32'd0, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("multu_big", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Multi-cycle multiply/divide unit with its own sequencing. Owns the HI/LO registers and the busy countdown.
- Sits in the E stage. Accepts MULT/MULTU/DIV/DIVU start pulses and MTHI/MTLO writes.
- Generates the pipeline stall request whenever the instruction in D is an MD-type instruction and the unit is starting or busy.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be at least 1).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be at least 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-high reset.
- Start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU; single-cycle pulse.
- MDOp  input  2  operation select, sampled with Start: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- A  input  32  rs operand (dividend / multiplicand).
- B  input  32  rt operand (divisor / multiplier).
- MTHI  input  1  write A into HI.
- MTLO  input  1  write A into LO.
- D_MDType  input  1  D-stage instruction is any MD-type instruction, including MFHI/MFLO.
- Busy  output  1  operation in progress.
- Stall  output  1  stall request to the hazard unit.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0.
  - Busy=0, HI=0, LO=0.
  - Pending result discarded.
- States:
  - IDLE: counter=0, Busy=0.
  - RUN: counter>0, Busy=1.
- IDLE with Start at edge t:
  - Compute the full result from A, B, MDOp combinationally and latch it into internal pending registers (pHI, pLO).
  - Load counter with MULT_CYCLES for MDOp 0/1, or DIV_CYCLES for MDOp 2/3.
  - Enter RUN. Busy is high from cycle t+1 through cycle t+N inclusive.
- RUN, each edge: counter decrements.
  - At the edge where counter goes 1->0: HI<=pHI, LO<=pLO, return to IDLE.
  - New HI/LO is visible in the first cycle with Busy=0.
- HI/LO are unchanged during RUN; intermediate values are never exposed.
- MULT: {HI,LO} = signed(A) * signed(B), 64-bit product.
- MULTU: {HI,LO} = A * B, unsigned 64-bit product.
- DIV (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (B=0, DIV or DIVU): unit runs the full DIV_CYCLES with Busy asserted; HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - In IDLE without Start: write at the next edge.
  - In IDLE with Start in the same cycle: Start has priority; the MT write is dropped.
  - In RUN: ignored.
  - MTHI and MTLO together: both registers are written with A.
- Start while in RUN: ignored. Counter and pending result are not disturbed. Upstream stall logic must prevent this case.
- Stall = D_MDType & (Start | Busy). Combinational, no latency.
  - Stall is high in the Start cycle and in every Busy cycle.
  - Stall falls in the cycle HI/LO hold the new result, so a stalled MFHI/MFLO reads the completed value.
- Reset mid-operation: operation aborted. HI/LO stay 0 and no late write occurs after reset deasserts.

Test Plan:
- MULT, A=0xFFFFFFFE, B=3, Start in cycle 1 -> Busy=1 in cycles 2-6; cycle 7 shows Busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO stay 0 in cycles 2-6.
- MULTU, A=0xFFFFFFFE, B=3 -> after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2, with D_MDType held 1 -> Busy high for 10 cycles; Stall high in the Start cycle plus all 10 Busy cycles, then low; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678 while IDLE, then DIVU A=5, B=0 -> HI=0x12345678 next cycle; after 10 busy cycles HI=0x12345678 and LO=0 are unchanged.
- Start MULT A=2, B=3; assert reset in the 3rd Busy cycle for 1 cycle -> Busy, HI, LO drop to 0 immediately; they stay 0 for 10 further cycles.
- During DIV RUN, pulse Start with MDOp=0 and MTLO with A=0xAAAA -> both ignored; DIV completes on the original schedule with the original result.
